sumador_serie_nbits: RTL and testbench

Multi-cycle, parametrised N-bit adder/subtractor for the ALU datapath. It processes operands K bits per clock, least-significant chunk first, through a single K-bit ripple slice. This trades latency for area on wide datapaths. It runs a start/busy/done handshake and reports carry, signed overflow and zero flags alongside the result.

---
 rtl/alu_pkg.sv | 18 +
 rtl/sumador_serie_nbits_if.sv | 29 ++
 rtl/sumador_bloque.sv | 25 ++
 rtl/sumador_serie_nbits.sv | 111 +++++++++++
 tb/tb_sumador_serie_nbits.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, add/sub mode names and the
// chunk-count helper used by the multi-cycle arithmetic blocks.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int calc_chunks(input int n, input int k);
    return n / k;
  endfunction

endpackage

// File: rtl/sumador_serie_nbits_if.sv
// Start/busy/done handshake plus operand and flag bus of the serial adder.
// The master side issues requests and the slave side is the adder itself.
interface sumador_serie_nbits_if #(
  parameter int N = 32
);

  logic         start;
  logic         sub;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         c_out;
  logic         overflow;
  logic         zero;

  modport master (
    output start, sub, a_in, b_in, c_in,
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, sub, a_in, b_in, c_in,
    output busy, done, result, c_out, overflow, zero
  );

endinterface

// File: rtl/sumador_bloque.sv
// Purely combinational K-bit ripple-carry slice, time-multiplexed by the
// serial adder across the chunks of a wide operand.
module sumador_bloque #(
  parameter int K = 8
) (
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  input  logic         c_i,
  output logic [K-1:0] sum_o,
  output logic         c_o
);

  logic carry;

  always_comb begin
    sum_o = '0;
    carry = c_i;
    for (int i = 0; i < K; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/sumador_serie_nbits.sv
// Multi-cycle N-bit adder/subtractor: one K-bit slice walks the operands
// LSB chunk first, then reports result with carry, overflow and zero flags.
module sumador_serie_nbits
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  sumador_serie_nbits_if.slave bus
);

  localparam int M  = calc_chunks(N, K);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  if ((K < 1) || (K > N) || ((N % K) != 0)) begin : g_bad_cfg
    $error("sumador_serie_nbits: N must be a multiple of K with 1 <= K <= N");
  end

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [N-1:0]    opA_q;
  logic [N-1:0]    opB_q;
  logic            carry_q;
  logic [N-1:0]    result_q;
  logic [N-1:0]    result_d;
  logic            c_out_q;
  logic            ovf_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;
  logic [K-1:0]    slice_sum;
  logic            slice_co;

  sumador_bloque #(.K(K)) u_slice (
    .a_i   (opA_q[idx_q*K +: K]),
    .b_i   (opB_q[idx_q*K +: K]),
    .c_i   (carry_q),
    .sum_o (slice_sum),
    .c_o   (slice_co)
  );

  always_comb begin
    result_d = result_q;
    result_d[idx_q*K +: K] = slice_sum;
  end

  // Subtraction is folded into addition at accept time (invert B, carry-in 1),
  // so the RUN loop never needs to know the mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            opA_q    <= bus.a_in;
            opB_q    <= (bus.sub == MODE_SUB) ? ~bus.b_in : bus.b_in;
            carry_q  <= (bus.sub == MODE_SUB) ? 1'b1 : bus.c_in;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= slice_co;
          if (idx_q == LAST_IDX) begin
            c_out_q <= slice_co;
            ovf_q   <= (opA_q[N-1] == opB_q[N-1]) && (result_d[N-1] != opA_q[N-1]);
            zero_q  <= (result_d == '0);
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_sumador_serie_nbits.sv
// Bench for the serial adder: three instances (K=4, K=16, K=1, all N=16) share
// one stimulus stream and are each checked every cycle against an arithmetic model.
module tb_sumador_serie_nbits;
  import alu_pkg::*;

  localparam int NB = 16;
  localparam int MV [3] = '{4, 1, 16};
  localparam int KV [3] = '{4, 16, 1};

  int checks = 0;
  int failures = 0;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            sub;
  logic            cIn;
  logic [NB-1:0]   aIn;
  logic [NB-1:0]   bIn;

  sumador_serie_nbits_if #(.N(NB)) ifK4 ();
  sumador_serie_nbits_if #(.N(NB)) ifK16 ();
  sumador_serie_nbits_if #(.N(NB)) ifK1 ();

  assign ifK4.start  = start;
  assign ifK4.sub    = sub;
  assign ifK4.a_in   = aIn;
  assign ifK4.b_in   = bIn;
  assign ifK4.c_in   = cIn;
  assign ifK16.start = start;
  assign ifK16.sub   = sub;
  assign ifK16.a_in  = aIn;
  assign ifK16.b_in  = bIn;
  assign ifK16.c_in  = cIn;
  assign ifK1.start  = start;
  assign ifK1.sub    = sub;
  assign ifK1.a_in   = aIn;
  assign ifK1.b_in   = bIn;
  assign ifK1.c_in   = cIn;

  sumador_serie_nbits #(.N(NB), .K(4))  u_k4  (.clk(clk), .rst_n(rst_n), .bus(ifK4));
  sumador_serie_nbits #(.N(NB), .K(16)) u_k16 (.clk(clk), .rst_n(rst_n), .bus(ifK16));
  sumador_serie_nbits #(.N(NB), .K(1))  u_k1  (.clk(clk), .rst_n(rst_n), .bus(ifK1));

  logic          dBusy [3];
  logic          dDone [3];
  logic [NB-1:0] dRes  [3];
  logic          dCout [3];
  logic          dOvf  [3];
  logic          dZero [3];

  assign dBusy[0] = ifK4.busy;   assign dBusy[1] = ifK16.busy;   assign dBusy[2] = ifK1.busy;
  assign dDone[0] = ifK4.done;   assign dDone[1] = ifK16.done;   assign dDone[2] = ifK1.done;
  assign dRes[0]  = ifK4.result; assign dRes[1]  = ifK16.result; assign dRes[2]  = ifK1.result;
  assign dCout[0] = ifK4.c_out;  assign dCout[1] = ifK16.c_out;  assign dCout[2] = ifK1.c_out;
  assign dOvf[0]  = ifK4.overflow; assign dOvf[1] = ifK16.overflow; assign dOvf[2] = ifK1.overflow;
  assign dZero[0] = ifK4.zero;   assign dZero[1] = ifK16.zero;   assign dZero[2] = ifK1.zero;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: returns {overflow, zero, c_out, result} from integer arithmetic.
  function automatic logic [NB+2:0] refOp(input logic s, input logic [NB-1:0] a,
                                          input logic [NB-1:0] b, input logic c);
    int ua, ub, sa, sb, ures, sres;
    logic [NB-1:0] res;
    logic co, ov;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s == MODE_SUB) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + int'(c);
      sres = sa + sb + int'(c);
      co   = (ures > 65535);
    end
    res = ures[NB-1:0];
    ov  = (sres > 32767) || (sres < -32768);
    return {ov, (res == '0), co, res};
  endfunction

  int            phase [3];
  logic          pS    [3];
  logic          pC    [3];
  logic [NB-1:0] pA    [3];
  logic [NB-1:0] pB    [3];
  logic [NB+2:0] eOut  [3];

  // Model timeline per instance: phase 0 idle, 1..M running, M+1 the done cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        phase[d] <= 0;
        eOut[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (phase[d] == 0) begin
          if (start) begin
            phase[d] <= 1;
            pS[d] <= sub;
            pC[d] <= cIn;
            pA[d] <= aIn;
            pB[d] <= bIn;
          end
        end else if (phase[d] == MV[d] + 1) begin
          phase[d] <= 0;
        end else begin
          phase[d] <= phase[d] + 1;
          if (phase[d] == MV[d])
            eOut[d] <= refOp(pS[d], pA[d], pB[d], pC[d]);
        end
      end
    end
  end

  // Handshake is checked every cycle; held result and flags only when defined.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("busy_k%0d", KV[d]), 32'(dBusy[d]), 32'(phase[d] != 0));
      checkOutput($sformatf("done_k%0d", KV[d]), 32'(dDone[d]), 32'(phase[d] == MV[d] + 1));
      if (phase[d] == 0 || phase[d] == MV[d] + 1) begin
        checkOutput($sformatf("result_k%0d", KV[d]), 32'(dRes[d]), 32'(eOut[d][NB-1:0]));
        checkOutput($sformatf("cout_k%0d", KV[d]), 32'(dCout[d]), 32'(eOut[d][NB]));
        checkOutput($sformatf("zero_k%0d", KV[d]), 32'(dZero[d]), 32'(eOut[d][NB+1]));
        checkOutput($sformatf("ovf_k%0d", KV[d]), 32'(dOvf[d]), 32'(eOut[d][NB+2]));
      end
    end
  end

  logic [NB-1:0] capRes;
  logic          capCout, capOvf, capZero;

  task automatic waitIdle();
    int n;
    n = 0;
    while ((dBusy[0] || dBusy[1] || dBusy[2]) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", 32'(dBusy[0] || dBusy[1] || dBusy[2]), 32'd0);
  endtask

  // One request on all instances; measures accept-to-done latency of each.
  task automatic applyStimulus(input logic s, input logic [NB-1:0] a,
                               input logic [NB-1:0] b, input logic c);
    int lat [3];
    int cyc;
    waitIdle();
    sub = s; aIn = a; bIn = b; cIn = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    aIn = 16'($urandom);
    bIn = 16'($urandom);
    sub = 1'($urandom);
    cIn = 1'($urandom);
    lat = '{0, 0, 0};
    cyc = 1;
    for (int i = 0; i < 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (dDone[d] && lat[d] == 0) begin
          lat[d] = cyc;
          if (d == 0) begin
            capRes = dRes[0]; capCout = dCout[0]; capOvf = dOvf[0]; capZero = dZero[0];
          end
        end
      end
    end
    for (int d = 0; d < 3; d++)
      checkOutput($sformatf("latency_k%0d", KV[d]), 32'(lat[d]), 32'(MV[d] + 1));
  endtask

  task automatic checkK4(input string name, input logic [NB-1:0] r, input logic co,
                         input logic ov, input logic z);
    checkOutput({name, "_res"},  32'(capRes),  32'(r));
    checkOutput({name, "_cout"}, 32'(capCout), 32'(co));
    checkOutput({name, "_ovf"},  32'(capOvf),  32'(ov));
    checkOutput({name, "_zero"}, 32'(capZero), 32'(z));
  endtask

  initial begin
    int doneCnt;
    logic [NB-1:0] gotRes;
    rst_n = 1'b0; start = 1'b0; sub = MODE_ADD; cIn = 1'b0; aIn = '0; bIn = '0;
    gotRes = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy",   32'(dBusy[0]), 32'd0);
    checkOutput("reset_done",   32'(dDone[0]), 32'd0);
    checkOutput("reset_result", 32'(dRes[0]),  32'd0);
    checkOutput("reset_flags",  32'({dCout[0], dOvf[0], dZero[0]}), 32'd0);
    rst_n = 1'b1;

    checkOutput("model_add", 32'(refOp(MODE_ADD, 16'h1234, 16'h0FFF, 1'b0)), 32'h0_2233);
    checkOutput("model_sub", 32'(refOp(MODE_SUB, 16'h7FFF, 16'hFFFF, 1'b0)), 32'h4_8000);
    checkOutput("model_eq",  32'(refOp(MODE_SUB, 16'h0005, 16'h0005, 1'b0)), 32'h3_0000);

    applyStimulus(MODE_ADD, 16'h1234, 16'h0FFF, 1'b0); checkK4("add_basic",  16'h2233, 1'b0, 1'b0, 1'b0);
    applyStimulus(MODE_ADD, 16'hFFFF, 16'h0001, 1'b0); checkK4("add_wrap",   16'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(MODE_ADD, 16'hFFFF, 16'h0001, 1'b1); checkK4("add_wrapc",  16'h0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(MODE_ADD, 16'h7FFF, 16'h0001, 1'b0); checkK4("add_ovf",    16'h8000, 1'b0, 1'b1, 1'b0);
    applyStimulus(MODE_SUB, 16'h7FFF, 16'hFFFF, 1'b0); checkK4("sub_ovf",    16'h8000, 1'b0, 1'b1, 1'b0);
    applyStimulus(MODE_SUB, 16'h0005, 16'h0005, 1'b0); checkK4("sub_zero",   16'h0000, 1'b1, 1'b0, 1'b1);

    // A start pulse in RUN must neither restart nor disturb the K=4 operation.
    waitIdle();
    sub = MODE_ADD; aIn = 16'h1111; bIn = 16'h2222; cIn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aIn = 16'hFFFF; bIn = 16'hFFFF; sub = MODE_SUB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dDone[0]) begin
        doneCnt++;
        gotRes = dRes[0];
      end
    end
    checkOutput("busy_start_dones",  32'(doneCnt), 32'd1);
    checkOutput("busy_start_result", 32'(gotRes),  32'h3333);

    // Held start: K=4 completes an operation every M+2 = 6 cycles.
    waitIdle();
    sub = MODE_ADD; aIn = 16'h4000; bIn = 16'h4000; cIn = 1'b0; start = 1'b1;
    doneCnt = 0;
    repeat (18) begin
      @(negedge clk);
      if (dDone[0]) doneCnt++;
    end
    start = 1'b0;
    checkOutput("held_start_dones", 32'(doneCnt), 32'd3);

    // Asynchronous reset with idx=2 in flight; overflow is still set from above.
    waitIdle();
    sub = MODE_ADD; aIn = 16'h0F0F; bIn = 16'h0101; cIn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrun_rst_busy",   32'(dBusy[0]), 32'd0);
    checkOutput("midrun_rst_done",   32'(dDone[0]), 32'd0);
    checkOutput("midrun_rst_result", 32'(dRes[0]),  32'd0);
    checkOutput("midrun_rst_flags",  32'({dCout[0], dOvf[0], dZero[0]}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(MODE_ADD, 16'h00FF, 16'h0001, 1'b0); checkK4("after_rst", 16'h0100, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 120; i++)
      applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

    // Free-running random starts, including requests while busy.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = 1'($urandom);
      sub   = 1'($urandom);
      cIn   = 1'($urandom);
      aIn   = 16'($urandom);
      bIn   = 16'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
